// File: rtl/amplifier.sv
// Programmable-gain multiplier: one write port either loads the gain or submits
// a tagged 8-bit sample. Tag and product come back on the next cycle.
module amplifier #(
   parameter int WR_DATA_WIDTH = 16,
   parameter int RD_DATA_WIDTH = 32,
   parameter int SCALER_WIDTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic                     set_scaler_i,
   input  logic [WR_DATA_WIDTH-1:0] wr_data_i,
   output logic                     rd_val_o,
   output logic [RD_DATA_WIDTH-1:0] rd_data_o,
   output logic [SCALER_WIDTH-1:0]  scaler_o
);

   localparam int TAG_W  = 8;
   localparam int BASE_W = 8;
   localparam int PROD_W = RD_DATA_WIDTH - TAG_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [PROD_W-1:0] product;
   } rsp_t;

   logic              load;
   logic              sample;
   rsp_t              rsp_d;
   rsp_t              rsp_q;
   logic              val_q;
   logic [SCALER_WIDTH-1:0] scaler_q;

   assign load   = wr_en_i &  set_scaler_i;
   assign sample = wr_en_i & ~set_scaler_i;

   // Product uses the gain registered before this edge; 8x16 fits 24 bits exactly.
   always_comb begin
      rsp_d         = '0;
      rsp_d.tag     = wr_data_i[WR_DATA_WIDTH-1 -: TAG_W];
      rsp_d.product = PROD_W'(wr_data_i[BASE_W-1:0]) * PROD_W'(scaler_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scaler_q <= SCALER_WIDTH'(1);
         val_q    <= 1'b0;
         rsp_q    <= '0;
      end else begin
         val_q <= sample;
         if (load)
            scaler_q <= wr_data_i[SCALER_WIDTH-1:0];
         if (sample)
            rsp_q <= rsp_d;
      end
   end

   assign rd_val_o  = val_q;
   assign rd_data_o = rsp_q;
   assign scaler_o  = scaler_q;

endmodule

// File: tb/tb_amplifier.sv
// Directed bench for amplifier: a small reference model pushes expected results
// into a queue at drive time; results are popped when rd_val_o fires.
module tb_amplifier;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        wr_en_i;
   logic        set_scaler_i;
   logic [15:0] wr_data_i;
   logic        rd_val_o;
   logic [31:0] rd_data_o;
   logic [15:0] scaler_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [15:0] m_scaler;
   logic [31:0] m_data;
   logic        m_val;

   always #5 clk = ~clk;

   amplifier #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(32), .SCALER_WIDTH(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .wr_en_i      (wr_en_i),
      .set_scaler_i (set_scaler_i),
      .wr_data_i    (wr_data_i),
      .rd_val_o     (rd_val_o),
      .rd_data_o    (rd_data_o),
      .scaler_o     (scaler_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the model, then check all outputs after the edge.
   task automatic cycle(input logic rst, input logic en, input logic set,
                        input logic [15:0] data);
      logic [31:0] e;
      rst_i = rst; wr_en_i = en; set_scaler_i = set; wr_data_i = data;
      if (rst) begin
         m_scaler = 16'd1; m_val = 1'b0; m_data = 32'd0;
         exp_q.delete();
      end else if (en && set) begin
         m_scaler = data; m_val = 1'b0;
      end else if (en) begin
         e = {data[15:8], 24'(data[7:0]) * 24'(m_scaler)};
         exp_q.push_back(e);
         m_data = e; m_val = 1'b1;
      end else begin
         m_val = 1'b0;
      end
      @(posedge clk); #1;
      chk("rd_val", 32'(rd_val_o), 32'(m_val));
      chk("scaler", 32'(scaler_o), 32'(m_scaler));
      if (rd_val_o === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_result", 32'(rd_val_o), 32'd0);
         else chk("sb_result", rd_data_o, exp_q.pop_front());
      end
      chk("rd_data_reg", rd_data_o, m_data);
   endtask

   initial begin
      rst_i = 1'b1; wr_en_i = 1'b0; set_scaler_i = 1'b0; wr_data_i = '0;
      m_scaler = 16'd1; m_data = '0; m_val = 1'b0;

      // reset for 2 cycles
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("reset_scaler", 32'(scaler_o), 32'd1);
      chk("reset_data", rd_data_o, 32'd0);

      // gain load then sample
      cycle(1'b0, 1'b1, 1'b1, 16'd100);
      chk("load100", 32'(scaler_o), 32'd100);
      cycle(1'b0, 1'b1, 1'b0, {8'd5, 8'd25});
      chk("t5x25", rd_data_o, 32'h050009C4);

      // back-to-back at max gain
      cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
      cycle(1'b0, 1'b1, 1'b0, {8'd1, 8'd255});
      chk("max_prod", rd_data_o, 32'h01FEFF01);
      cycle(1'b0, 1'b1, 1'b0, {8'd2, 8'd0});
      chk("zero_base", rd_data_o, 32'h02000000);

      // load immediately followed by sample, then idle hold
      cycle(1'b0, 1'b1, 1'b1, 16'd3);
      cycle(1'b0, 1'b1, 1'b0, {8'd7, 8'd10});
      chk("new_gain", rd_data_o, 32'h0700001E);
      cycle(1'b0, 1'b0, 1'b0, 16'hABCD);
      chk("idle_hold", rd_data_o, 32'h0700001E);
      cycle(1'b0, 1'b0, 1'b1, 16'h1234);
      chk("set_ignored", 32'(scaler_o), 32'd3);

      // zero gain still returns the tag
      cycle(1'b0, 1'b1, 1'b1, 16'd0);
      cycle(1'b0, 1'b1, 1'b0, {8'hA5, 8'd200});
      chk("zero_gain", rd_data_o, 32'hA5000000);

      // reset wins over a sample and a load in the same cycle
      cycle(1'b0, 1'b1, 1'b1, 16'd9);
      cycle(1'b1, 1'b1, 1'b0, {8'd4, 8'd4});
      chk("rst_sample_val", 32'(rd_val_o), 32'd0);
      chk("rst_sample_scl", 32'(scaler_o), 32'd1);
      cycle(1'b1, 1'b1, 1'b1, 16'd77);
      chk("rst_load_scl", 32'(scaler_o), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, {8'd6, 8'd9});
      chk("unity_after_rst", rd_data_o, 32'h06000009);

      // mixed random traffic
      for (int i = 0; i < 60; i++) begin
         cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), 16'($urandom));
      end
      cycle(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
